// File: rtl/fcvt_queue.sv
// Request FIFO and registered result slot around an external combinational int->float converter.
// Optional FCVT_STATS_EN adds saturating completion/stall counters (stat_done, stat_stall).
module fcvt_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_data,
  input  logic [TAG_W-1:0]           req_tag,
  output logic [31:0]                cvt_i,
  input  logic [31:0]                cvt_f,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [31:0]                res_data,
  output logic [TAG_W-1:0]           res_tag,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FCVT_STATS_EN
  ,
  output logic [31:0]                stat_done,
  output logic [31:0]                stat_stall
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]      r_data_mem [DEPTH];
  logic [TAG_W-1:0] r_tag_mem  [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_res_valid;
  logic [31:0]      r_res_data;
  logic [TAG_W-1:0] r_res_tag;

  logic w_push;
  logic w_pop;
  logic w_slot_free;
  logic w_empty;

  assign w_empty     = (r_count == '0);
  assign req_ready   = (r_count < DEPTH_C) && !flush;
  assign w_push      = req_valid && req_ready;
  assign w_slot_free = !r_res_valid || res_ready;
  assign w_pop       = !w_empty && w_slot_free;

  // Head data feeds the converter directly; zero when nothing is queued.
  assign cvt_i = w_empty ? 32'h0 : r_data_mem[r_rd_ptr];

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_tag   = r_res_tag;
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data_mem[r_wr_ptr] <= req_data;
      r_tag_mem[r_wr_ptr]  <= req_tag;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Flush drops the held result but leaves its data/tag in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= 32'h0;
      r_res_tag   <= '0;
    end else if (flush) begin
      r_res_valid <= 1'b0;
    end else if (w_pop) begin
      r_res_valid <= 1'b1;
      r_res_data  <= cvt_f;
      r_res_tag   <= r_tag_mem[r_rd_ptr];
    end else if (r_res_valid && res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

`ifdef FCVT_STATS_EN
  logic [31:0] r_stat_done;
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_done  <= 32'h0;
      r_stat_stall <= 32'h0;
    end else begin
      if (r_res_valid && res_ready && (r_stat_done != 32'hFFFF_FFFF))
        r_stat_done <= r_stat_done + 32'd1;
      if (r_res_valid && !res_ready && (r_stat_stall != 32'hFFFF_FFFF))
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_done  = r_stat_done;
  assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_fcvt_queue.sv
// Self-checking bench for fcvt_queue; models the external itof converter (round to nearest, ties away from zero).
module tb_fcvt_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 6;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_data;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      cvt_i;
  logic [31:0]      cvt_f;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic [CW-1:0]    count;
`ifdef FCVT_STATS_EN
  logic [31:0]      stat_done;
  logic [31:0]      stat_stall;
`endif

  int checks = 0;
  int errors = 0;

  fcvt_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_tag   (req_tag),
    .cvt_i     (cvt_i),
    .cvt_f     (cvt_f),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_tag   (res_tag),
    .count     (count)
`ifdef FCVT_STATS_EN
    ,
    .stat_done (stat_done),
    .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] itof(input logic [31:0] x);
    logic        sgn;
    logic [31:0] mag;
    logic [31:0] mant;
    logic [31:0] rem;
    logic [31:0] half;
    int          p;
    int          e;
    int          sh;
    if (x == 32'h0) return 32'h0;
    sgn = x[31];
    mag = sgn ? (~x + 32'd1) : x;
    p = 0;
    for (int b = 0; b < 32; b++) if (mag[b]) p = b;
    e = 127 + p;
    if (p <= 23) begin
      mant = mag << (23 - p);
    end else begin
      sh   = p - 23;
      mant = mag >> sh;
      rem  = mag & ((32'd1 << sh) - 32'd1);
      half = 32'd1 << (sh - 1);
      if (rem >= half) mant = mant + 32'd1;
      if (mant[24]) begin
        mant = mant >> 1;
        e    = e + 1;
      end
    end
    return {sgn, 8'(e), mant[22:0]};
  endfunction

  assign cvt_f = itof(cvt_i);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Handshakes observed at the negedge preceding each rising edge.
  logic             hs_push;
  logic             hs_pop;
  logic [31:0]      hs_data;
  logic [TAG_W-1:0] hs_tag;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    hs_push = req_valid && req_ready;
    hs_pop  = res_valid && res_ready;
    hs_data = res_data;
    hs_tag  = res_tag;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_data = '0; req_tag = '0; res_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt;
    int exp_tag;
    int cycles;
    int tag4_cycle;
    int sent;
    int got;
    int max_cnt;
    logic [TAG_W+31:0] q[$];
    logic [TAG_W+31:0] e;

    vecs[0] = '{32'h0000_0001, 6'd1,  32'h3F80_0000};
    vecs[1] = '{32'hFFFF_FFFF, 6'd2,  32'hBF80_0000};
    vecs[2] = '{32'h8000_0000, 6'd3,  32'hCF00_0000};
    vecs[3] = '{32'h0000_0000, 6'd4,  32'h0000_0000};
    vecs[4] = '{32'h0100_0001, 6'd5,  32'h4B80_0001};
    vecs[5] = '{32'h7FFF_FFFF, 6'd6,  32'h4F00_0000};
    vecs[6] = '{32'h0000_0003, 6'd7,  32'h4040_0000};
    vecs[7] = '{32'hFFFF_FFFD, 6'd63, 32'hC040_0000};

    // Reset state
    do_reset();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'h0);
    chk("rst_res_tag", 32'(res_tag), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_cvt_i", cvt_i, 32'h0);

    // Single requests with res_ready held high
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_data = vecs[i].data; req_tag = vecs[i].tag;
      step();
      req_valid = 1'b0;
      chk("vec_count_e0", 32'(count), 32'd1);
      chk("vec_latency_e0", 32'(res_valid), 32'd0);
      chk("vec_cvt_i", cvt_i, vecs[i].data);
      step();
      chk("vec_valid_e1", 32'(res_valid), 32'd1);
      chk("vec_data", res_data, vecs[i].exp);
      chk("vec_tag", 32'(res_tag), 32'(vecs[i].tag));
      chk("vec_count_e1", 32'(count), 32'd0);
      $display("vec %0d: in=%h tag=%0d -> res=%h", i, vecs[i].data, vecs[i].tag, res_data);
      step();
      chk("vec_valid_e2", 32'(res_valid), 32'd0);
    end
`ifdef FCVT_STATS_EN
    chk("stat_done_basic", stat_done, 32'd8);
    chk("stat_stall_basic", stat_stall, 32'd0);
`endif

    // Backpressure: res_ready low, tags 0..9 offered
    do_reset();
    res_ready = 1'b0;
    nxt = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1; req_data = 32'(nxt); req_tag = TAG_W'(nxt);
      cyc();
      if (hs_push) nxt++;
    end
    chk("bp_accepted", 32'(nxt), 32'd5);
    chk("bp_count_full", 32'(count), 32'd4);
    chk("bp_req_ready", 32'(req_ready), 32'd0);
    chk("bp_res_valid", 32'(res_valid), 32'd1);
    chk("bp_res_tag_stable", 32'(res_tag), 32'd0);
    cyc();
    chk("bp_res_tag_stable2", 32'(res_tag), 32'd0);
    chk("bp_res_data_stable", res_data, 32'h0);
    res_ready = 1'b1;
    exp_tag = 0; cycles = 0; tag4_cycle = -1;
    while (exp_tag < 10 && cycles < 60) begin
      req_valid = (nxt < 10); req_data = 32'(nxt); req_tag = TAG_W'(nxt);
      cyc();
      if (hs_push) nxt++;
      if (hs_pop) begin
        chk("bp_tag_order", 32'(hs_tag), 32'(exp_tag));
        chk("bp_data", hs_data, itof(32'(exp_tag)));
        $display("bp drain: tag=%0d data=%h cycle=%0d", hs_tag, hs_data, cycles);
        if (exp_tag == 4) tag4_cycle = cycles;
        exp_tag++;
      end
      cycles++;
    end
    req_valid = 1'b0;
    chk("bp_all_drained", 32'(exp_tag), 32'd10);
    chk("bp_drain_rate", 32'(tag4_cycle), 32'd4);

    // Streaming with random res_ready
    do_reset();
    sent = 0; got = 0; cycles = 0; max_cnt = 0;
    req_data = $urandom;
    while (got < 64 && cycles < 3000) begin
      req_valid = (sent < 64); req_tag = TAG_W'(sent);
      res_ready = 1'($urandom_range(0, 1));
      cyc();
      if (hs_push) begin
        q.push_back({req_tag, itof(req_data)});
        sent++;
        req_data = (sent % 16 == 5) ? 32'h8000_0000 : $urandom;
      end
      if (hs_pop) begin
        if (q.size() == 0) begin
          chk("st_unexpected_result", 32'(hs_tag), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("st_tag", 32'(hs_tag), 32'(e[TAG_W+31:32]));
          chk("st_data", hs_data, e[31:0]);
          $display("stream %0d: tag=%0d data=%h", got, hs_tag, hs_data);
        end
        got++;
      end
      if (int'(count) > max_cnt) max_cnt = int'(count);
      cycles++;
    end
    req_valid = 1'b0; res_ready = 1'b0;
    chk("st_all_results", 32'(got), 32'd64);
    chk("st_max_count", 32'(max_cnt <= DEPTH), 32'd1);

    // Flush mid-stream: 3 queued plus a held result
    do_reset();
    res_ready = 1'b0; nxt = 0; cycles = 0;
    while (nxt < 4 && cycles < 20) begin
      req_valid = 1'b1; req_data = 32'(nxt + 10); req_tag = TAG_W'(nxt + 10);
      cyc();
      if (hs_push) nxt++;
      cycles++;
    end
    req_valid = 1'b0;
    chk("fl_count_pre", 32'(count), 32'd3);
    chk("fl_res_valid_pre", 32'(res_valid), 32'd1);
    flush = 1'b1; req_valid = 1'b1; req_data = 32'h55; req_tag = 6'h33; res_ready = 1'b1;
    #1;
    chk("fl_req_ready", 32'(req_ready), 32'd0);
    step();
    flush = 1'b0; req_valid = 1'b0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_res_valid", 32'(res_valid), 32'd0);
    chk("fl_cvt_i", cvt_i, 32'h0);
    req_valid = 1'b1; req_data = 32'h3; req_tag = 6'h2A;
    step();
    req_valid = 1'b0;
    chk("fl_new_count", 32'(count), 32'd1);
    step();
    chk("fl_new_valid", 32'(res_valid), 32'd1);
    chk("fl_new_data", res_data, 32'h4040_0000);
    chk("fl_new_tag", 32'(res_tag), 32'h2A);
    $display("flush: new result tag=%0d data=%h", res_tag, res_data);
    step();
    chk("fl_no_extra", 32'(res_valid), 32'd0);
    chk("fl_empty_after", 32'(count), 32'd0);

    // Reset with FIFO full
    res_ready = 1'b0; nxt = 0; cycles = 0;
    while (nxt < 5 && cycles < 20) begin
      req_valid = 1'b1; req_data = 32'(nxt + 1); req_tag = TAG_W'(nxt + 1);
      cyc();
      if (hs_push) nxt++;
      cycles++;
    end
    chk("rm_full", 32'(count), 32'd4);
    chk("rm_held_data", res_data, 32'h3F80_0000);
    rst = 1'b1;
    step();
    chk("rm_count", 32'(count), 32'd0);
    chk("rm_res_valid", 32'(res_valid), 32'd0);
    chk("rm_res_data", res_data, 32'h0);
    chk("rm_res_tag", 32'(res_tag), 32'd0);
    chk("rm_cvt_i", cvt_i, 32'h0);
`ifdef FCVT_STATS_EN
    chk("rm_stat_done", stat_done, 32'd0);
    chk("rm_stat_stall", stat_stall, 32'd0);
`endif
    rst = 1'b0; req_valid = 1'b0;
    #1;
    chk("rm_req_ready", 32'(req_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
